spi_frame_decoder: RTL and testbench
====================================

SPI_FRAME_DECODER -- requirements
Module: spi_frame_decoder

Interface
REQ-001 Parameter: FRAME_BITS, 32, number of sclk rising edges that make a valid frame.
REQ-002 Parameter: ERR_W, 8, width of the frame-error counter.
REQ-003 Port: clock  in  1  single system clock; all state is on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: sclk  in  1  raw SPI clock, shared with the upstream shift stage.
REQ-006 Port: ss_n  in  1  raw SPI slave select, active-low.
REQ-007 Port: spi_data  in  32  parallel word from the upstream shift register.
REQ-008 Port: cmd_valid  out  1  decoded command is held on the cmd_* outputs.
REQ-009 Port: cmd_ready  in  1  consumer accepts the command.
REQ-010 Port: cmd_write  out  1  spi_data[31]; 1 means write, 0 means read.
REQ-011 Port: cmd_addr  out  7  spi_data[30:24].
REQ-012 Port: cmd_data  out  24  spi_data[23:0].
REQ-013 Port: overrun  out  1  sticky flag: a valid frame was dropped.
REQ-014 Port: clear_flags  in  1  synchronous clear of overrun and err_count.
REQ-015 Port: err_count  out  ERR_W  count of bad-length frames, saturating.

Function
REQ-016 sclk and ss_n SHALL each pass through a 3-flop shift synchronizer. Edge detection SHALL use bits [2:1], with 01 meaning a rising edge.
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and END.
- IDLE -> SHIFT on a synchronized ss_n falling edge (ss_n_s[2:1] == 10).
- SHIFT -> END on a synchronized ss_n rising edge (01).
- END -> IDLE unconditionally after one cycle.
REQ-018 On entry to SHIFT, the 6-bit bit counter SHALL clear to 0.
- In SHIFT, each synchronized sclk rising edge SHALL increment the counter.
- The counter SHALL saturate at 63.
REQ-019 In END with counter == FRAME_BITS, the frame SHALL be valid. Otherwise it SHALL be a frame error.
REQ-020 For a valid frame with cmd_valid = 0, or with cmd_valid = 1 and cmd_ready = 1 in the same cycle:
- spi_data SHALL be captured into the cmd_* registers.
- cmd_valid SHALL be 1 on the next cycle.
REQ-021 For a valid frame with cmd_valid = 1 and cmd_ready = 0:
- the frame SHALL be dropped;
- the cmd_* registers SHALL be unchanged;
- overrun SHALL be set to 1.
REQ-022 A frame error SHALL increment err_count, saturating at all-ones. It SHALL change no cmd_* output.
REQ-023 cmd_valid SHALL fall on the cycle after cmd_valid && cmd_ready, unless REQ-020 reloads it.
- cmd_* outputs SHALL be stable while cmd_valid = 1 and cmd_ready = 0.
REQ-024 clear_flags = 1 SHALL zero overrun and err_count on the next edge.
- If a set or increment event occurs in the same cycle, clear SHALL win.
REQ-025 Latency: cmd_valid SHALL rise exactly 4 clock cycles after the raw ss_n rising edge is sampled.
- 3 cycles are synchronizer.
- 1 cycle is the END decode and capture.
REQ-026 If ss_n is already low when reset deasserts, the FSM SHALL stay in IDLE until a full high-to-low ss_n transition is seen.
REQ-027 sclk edges seen in IDLE or END SHALL be ignored.
REQ-028 sclk is required to be at most clock/8, matching the upstream stage's sampling.

Reset
REQ-029 While reset = 1, the block SHALL be in the following state:
- FSM in IDLE;
- bit counter at 0;
- cmd_valid, cmd_write, cmd_addr and cmd_data at 0;
- overrun at 0 and err_count at 0;
- all synchronizer flops at 1 for ss_n and 0 for sclk.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no cmd_valid and no err_count change. The first post-reset frame SHALL then decode normally.

Verification
REQ-031 32-bit frame, spi_data = 0x8A123456, cmd_ready = 1 -> cmd_valid for 1 cycle with cmd_write = 1, cmd_addr = 0x0A, cmd_data = 0x123456; cmd_valid rises 4 cycles after ss_n rises.
REQ-032 31-bit frame, then a 33-bit frame -> err_count = 2, cmd_valid never asserts.
REQ-033 Two valid frames, cmd_ready held at 0 -> the first word is held on cmd_*, overrun = 1; after cmd_ready = 1, a single handshake completes.
REQ-034 err_count at 0xFF plus one more bad frame -> err_count stays 0xFF; clear_flags pulsed together with a bad frame -> err_count = 0.
REQ-035 reset pulsed after 16 sclk edges of a frame, followed by a clean 32-bit frame of 0x01000001 -> exactly one cmd_valid with cmd_write = 0, cmd_addr = 0x01, cmd_data = 0x000001.

Source files
------------

// File: rtl/spi_frame_decoder.sv
// SPI frame decoder: synchronizes raw sclk/ss_n, counts sclk edges per frame and
// hands well-formed 32-bit command words to a valid/ready consumer.
module spi_frame_decoder #(
  parameter int FRAME_BITS = 32,
  parameter int ERR_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic [31:0]      spi_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_write,
  output logic [6:0]       cmd_addr,
  output logic [23:0]      cmd_data,
  output logic             overrun,
  input  logic             clear_flags,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_END   = 2'd2
  } state_t;

  localparam logic [5:0]       CNT_MAX   = 6'd63;
  localparam logic [5:0]       FRAME_CNT = 6'(FRAME_BITS);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO  = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

  logic [2:0]       sclk_sync_r;
  logic [2:0]       ss_sync_r;
  logic [2:0]       fill_r;
  logic             armed_r;
  state_t           state_r;
  logic [5:0]       bit_cnt_r;
  logic             cmd_valid_r;
  logic             cmd_write_r;
  logic [6:0]       cmd_addr_r;
  logic [23:0]      cmd_data_r;
  logic             overrun_r;
  logic [ERR_W-1:0] err_count_r;

  logic sclk_rise_s;
  logic ss_fall_s;
  logic ss_rise_s;
  logic frame_end_s;
  logic frame_good_s;
  logic load_s;
  logic drop_s;
  logic err_inc_s;

  // Input synchronizers; fill_r marks which stages hold real post-reset samples so
  // the reset preload of ss_n cannot fake a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync_r <= 3'b000;
      ss_sync_r   <= 3'b111;
      fill_r      <= 3'b000;
      armed_r     <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[1:0], sclk};
      ss_sync_r   <= {ss_sync_r[1:0], ss_n};
      fill_r      <= {fill_r[1:0], 1'b1};
      if (fill_r[2] && ss_sync_r[2]) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // Edge detection and end-of-frame classification.
  always_comb begin
    sclk_rise_s  = (sclk_sync_r[2:1] == 2'b01);
    ss_fall_s    = armed_r && (ss_sync_r[2:1] == 2'b10);
    ss_rise_s    = (ss_sync_r[2:1] == 2'b01);
    frame_end_s  = (state_r == ST_END);
    frame_good_s = frame_end_s && (bit_cnt_r == FRAME_CNT);
    load_s       = frame_good_s && (!cmd_valid_r || cmd_ready);
    drop_s       = frame_good_s && cmd_valid_r && !cmd_ready;
    err_inc_s    = frame_end_s && (bit_cnt_r != FRAME_CNT) && (err_count_r != ERR_MAX);
  end

  // Frame FSM, bit counter, command registers and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 6'd0;
      cmd_valid_r <= 1'b0;
      cmd_write_r <= 1'b0;
      cmd_addr_r  <= 7'd0;
      cmd_data_r  <= 24'd0;
      overrun_r   <= 1'b0;
      err_count_r <= ERR_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ss_fall_s) begin
            state_r   <= ST_SHIFT;
            bit_cnt_r <= 6'd0;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // A frame-closing ss_n edge takes priority over a coincident sclk edge.
          if (ss_rise_s) begin
            state_r <= ST_END;
          end else if (sclk_rise_s && (bit_cnt_r != CNT_MAX)) begin
            bit_cnt_r <= bit_cnt_r + 6'd1;
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        ST_END: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (load_s) begin
        cmd_valid_r <= 1'b1;
        cmd_write_r <= spi_data[31];
        cmd_addr_r  <= spi_data[30:24];
        cmd_data_r  <= spi_data[23:0];
      end else if (cmd_valid_r && cmd_ready) begin
        cmd_valid_r <= 1'b0;
      end else begin
        cmd_valid_r <= cmd_valid_r;
      end

      if (clear_flags) begin
        overrun_r   <= 1'b0;
        err_count_r <= ERR_ZERO;
      end else begin
        if (drop_s) begin
          overrun_r <= 1'b1;
        end else begin
          overrun_r <= overrun_r;
        end
        if (err_inc_s) begin
          err_count_r <= err_count_r + ERR_ONE;
        end else begin
          err_count_r <= err_count_r;
        end
      end
    end
  end

  assign cmd_valid = cmd_valid_r;
  assign cmd_write = cmd_write_r;
  assign cmd_addr  = cmd_addr_r;
  assign cmd_data  = cmd_data_r;
  assign overrun   = overrun_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Randomized bench for spi_frame_decoder: a frame-level reference model predicts
// the command/flag outputs every cycle, with directed literal checks alongside.
module tb_spi_frame_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        ss_n = 1'b1;
  logic [31:0] spi_data = 32'd0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        cmd_write;
  logic [6:0]  cmd_addr;
  logic [23:0] cmd_data;
  logic        overrun;
  logic        clear_flags = 1'b0;
  logic [7:0]  err_count;

  spi_frame_decoder #(.FRAME_BITS(32), .ERR_W(8)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .ss_n(ss_n), .spi_data(spi_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .overrun(overrun),
    .clear_flags(clear_flags), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    int          nbits;
    logic [31:0] word;
  } frame_t;

  frame_t      pend[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          rand_mode = 1'b0;

  // Reference state: what the consumer should currently see.
  bit          m_valid = 1'b0;
  logic [31:0] m_word = 32'd0;
  bit          m_ovr = 1'b0;
  int          m_err = 0;
  frame_t      fr;
  bit          ev_good, ev_bad, accept;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each clock edge, then compare once the DUT has settled.
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_valid = 1'b0;
      m_word  = 32'd0;
      m_ovr   = 1'b0;
      m_err   = 0;
      pend.delete();
    end else begin
      ev_good = 1'b0;
      ev_bad  = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        fr = pend.pop_front();
        if (fr.nbits == 32) ev_good = 1'b1;
        else ev_bad = 1'b1;
      end
      accept = !m_valid || cmd_ready;
      if (m_valid && cmd_ready) m_valid = 1'b0;
      if (ev_good && accept) begin
        m_valid = 1'b1;
        m_word  = fr.word;
      end
      if (clear_flags) begin
        m_ovr = 1'b0;
        m_err = 0;
      end else begin
        if (ev_good && !accept) m_ovr = 1'b1;
        if (ev_bad && m_err < 255) m_err = m_err + 1;
      end
    end
    #1;
    check("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_valid});
    check("cmd_write", {31'd0, cmd_write}, {31'd0, m_word[31]});
    check("cmd_addr", {25'd0, cmd_addr}, {25'd0, m_word[30:24]});
    check("cmd_data", {8'd0, cmd_data}, {8'd0, m_word[23:0]});
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    check("err_count", {24'd0, err_count}, m_err);
  end

  // Random consumer back-pressure and occasional flag clears.
  initial begin
    forever begin
      @(negedge clock);
      if (rand_mode) begin
        cmd_ready   = ($urandom_range(0, 3) != 0);
        clear_flags = ($urandom_range(0, 199) == 0);
      end
    end
  end

  task automatic sclk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      repeat (4) @(negedge clock);
      sclk = 1'b0;
      repeat (4) @(negedge clock);
    end
  endtask

  // Drives one frame and returns on the negedge where ss_n has just been raised.
  task automatic send_frame(input logic [31:0] word, input int nbits);
    frame_t f;
    @(negedge clock);
    spi_data = word;
    ss_n = 1'b0;
    repeat (4) @(negedge clock);
    sclk_pulses(nbits);
    ss_n = 1'b1;
    f.due   = cyc + 4;
    f.nbits = nbits;
    f.word  = word;
    pend.push_back(f);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clock);
  endtask

  int nb;
  logic [31:0] wa, wb;

  initial begin
    repeat (3) @(negedge clock);
    check("reset_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset_err", {24'd0, err_count}, 32'd0);
    check("reset_data", {8'd0, cmd_data}, 32'd0);
    reset = 1'b0;
    gap(6);

    // Single valid frame: cmd_valid on the 4th edge counting the one that samples ss_n high.
    send_frame(32'h8A123456, 32);
    repeat (3) @(posedge clock);
    #2;
    check("lat_early", {31'd0, cmd_valid}, 32'd0);
    @(posedge clock);
    #2;
    check("lat_valid", {31'd0, cmd_valid}, 32'd1);
    check("lat_write", {31'd0, cmd_write}, 32'd1);
    check("lat_addr", {25'd0, cmd_addr}, 32'h0A);
    check("lat_data", {8'd0, cmd_data}, 32'h123456);
    @(posedge clock);
    #2;
    check("lat_drop", {31'd0, cmd_valid}, 32'd0);
    gap(6);

    // Short and long frames count as errors.
    send_frame(32'hFFFFFFFF, 31);
    gap(6);
    send_frame(32'h7FFFFFFF, 33);
    gap(6);
    check("bad_len_err", {24'd0, err_count}, 32'd2);
    check("bad_len_valid", {31'd0, cmd_valid}, 32'd0);

    // Back-pressure: first word held, second dropped with overrun.
    cmd_ready = 1'b0;
    wa = 32'h1155AA33;
    wb = 32'hC2778899;
    send_frame(wa, 32);
    gap(6);
    send_frame(wb, 32);
    gap(6);
    check("hold_valid", {31'd0, cmd_valid}, 32'd1);
    check("hold_addr", {25'd0, cmd_addr}, 32'h11);
    check("hold_data", {8'd0, cmd_data}, 32'h55AA33);
    check("hold_overrun", {31'd0, overrun}, 32'd1);
    cmd_ready = 1'b1;
    @(negedge clock);
    check("handshake_done", {31'd0, cmd_valid}, 32'd0);
    gap(4);
    check("no_second", {31'd0, cmd_valid}, 32'd0);

    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    check("clear_ovr", {31'd0, overrun}, 32'd0);
    check("clear_err", {24'd0, err_count}, 32'd0);

    // Error counter saturation, then clear racing a bad frame.
    for (int i = 0; i < 255; i++) begin
      send_frame($urandom, $urandom_range(0, 3));
      gap(6);
    end
    check("err_full", {24'd0, err_count}, 32'hFF);
    send_frame(32'h0, 2);
    gap(6);
    check("err_sat", {24'd0, err_count}, 32'hFF);
    send_frame(32'h0, 5);
    gap(3);
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    gap(2);
    check("clear_wins", {24'd0, err_count}, 32'd0);

    // Randomized frames with random back-pressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        5:       nb = 31;
        6:       nb = 33;
        7:       nb = $urandom_range(0, 40);
        8:       nb = $urandom_range(60, 70);
        default: nb = 32;
      endcase
      send_frame($urandom, nb);
      gap($urandom_range(6, 20));
    end
    rand_mode = 1'b0;
    cmd_ready = 1'b1;
    clear_flags = 1'b0;
    gap(4);

    // Reset mid-frame with ss_n still low, stray sclk edges, then a clean frame.
    @(negedge clock);
    spi_data = $urandom;
    ss_n = 1'b0;
    repeat (4) @(negedge clock);
    sclk_pulses(16);
    reset = 1'b1;
    gap(2);
    reset = 1'b0;
    gap(4);
    sclk_pulses(3);
    ss_n = 1'b1;
    gap(8);
    check("abort_valid", {31'd0, cmd_valid}, 32'd0);
    check("abort_err", {24'd0, err_count}, 32'd0);
    send_frame(32'h01000001, 32);
    repeat (4) @(posedge clock);
    #2;
    check("post_valid", {31'd0, cmd_valid}, 32'd1);
    check("post_write", {31'd0, cmd_write}, 32'd0);
    check("post_addr", {25'd0, cmd_addr}, 32'h01);
    check("post_data", {8'd0, cmd_data}, 32'h000001);
    @(posedge clock);
    #2;
    check("post_single", {31'd0, cmd_valid}, 32'd0);
    gap(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
